adder_tree_1d_p4: RTL and testbench

- Pipelined, radix-4 signed adder tree that reduces a 1-D vector of INPUT_SIZE words to one sum.
- In the softmax datapath it sums the exponential-table outputs before the reciprocal lookup.
- It is the sibling of the mult_op_wrap registered multiplier in the same datapath.
- One register level per tree level gives fixed, throughput-1 latency.

---
 rtl/adder_tree_1d_p4.sv | 110 +++++++++++
 tb/tb_adder_tree_1d_p4.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_1d_p4.sv
// Pipelined radix-4 signed adder tree: reduces INPUT_SIZE words to one WIDTH-bit sum.
// Latency: L = ceil(log4(INPUT_SIZE)) cycles (minimum 1), one register level per tree level.
// Backpressure: none; accepts a new vector every cycle. Optional ADDER_TREE_SAT_EN clamps each node.
module adder_tree_1d_p4 #(
    parameter int WIDTH      = 16,
    parameter int INPUT_SIZE = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] input_data [INPUT_SIZE-1:0],
    output logic signed [WIDTH-1:0] output_data
);

    // Number of register levels: keep grouping by four until one node remains.
    function automatic int level_count(input int n);
        int l;
        int c;
        l = 0;
        c = n;
        do begin
            c = (c + 3) / 4;
            l++;
        end while (c > 1);
        return l;
    endfunction

    // Node count at a given level (level 0 is the input vector itself).
    function automatic int nodes_at(input int l);
        int c;
        c = INPUT_SIZE;
        for (int i = 0; i < l; i++) c = (c + 3) / 4;
        return c;
    endfunction

    // Start index of a level inside the flat node array.
    function automatic int offset_of(input int l);
        int o;
        o = 0;
        for (int i = 0; i < l; i++) o += nodes_at(i);
        return o;
    endfunction

    localparam int LEVELS = level_count(INPUT_SIZE);
    localparam int TOTAL  = offset_of(LEVELS + 1);

`ifdef ADDER_TREE_SAT_EN
    // Two guard bits are enough for a sum of four WIDTH-bit operands.
    localparam int SW = WIDTH + 2;
`else
    localparam int SW = WIDTH;
`endif

    // Every level laid end to end: inputs first, the final single node last.
    logic signed [WIDTH-1:0] node [TOTAL];

    for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_in
        assign node[i] = input_data[i];
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int NIN  = nodes_at(l - 1);
        localparam int NOUT = nodes_at(l);
        localparam int IOFF = offset_of(l - 1);
        localparam int OOFF = offset_of(l);

        for (genvar k = 0; k < NOUT; k++) begin : g_node
            logic signed [SW-1:0]    op [4];
            logic signed [SW-1:0]    sum_w;
            logic signed [WIDTH-1:0] nxt;
            logic signed [WIDTH-1:0] q;

            // Missing operands in the last node of a level contribute zero.
            for (genvar j = 0; j < 4; j++) begin : g_op
                if (4 * k + j < NIN) begin : g_used
                    assign op[j] = SW'(node[IOFF + 4 * k + j]);
                end else begin : g_pad
                    assign op[j] = '0;
                end
            end

            assign sum_w = op[0] + op[1] + op[2] + op[3];

`ifdef ADDER_TREE_SAT_EN
            localparam logic signed [SW-1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
            localparam logic signed [SW-1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};

            // Clamp the widened node sum into the signed WIDTH-bit range.
            always_comb begin
                nxt = sum_w[WIDTH-1:0];
                if (sum_w > MAXV)      nxt = MAXV[WIDTH-1:0];
                else if (sum_w < MINV) nxt = MINV[WIDTH-1:0];
            end
`else
            // Plain wrap-around: the WIDTH-bit sum is already modulo 2^WIDTH.
            assign nxt = sum_w;
`endif

            // Register the node sum; reset flushes all in-flight partial sums.
            always_ff @(posedge clk) begin
                if (reset) q <= '0;
                else       q <= nxt;
            end

            assign node[OOFF + k] = q;
        end
    end

    assign output_data = node[TOTAL-1];

endmodule

// File: tb/tb_adder_tree_1d_p4.sv
module tb_adder_tree_1d_p4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic signed [15:0] in10 [9:0];
    logic signed [15:0] in3  [2:0];
    logic signed [15:0] in1  [0:0];
    logic signed [15:0] in17 [16:0];
    logic signed [15:0] out10, out3, out1, out17;

    int n_cmp = 0;
    int n_bad = 0;

    adder_tree_1d_p4 #(.WIDTH(16), .INPUT_SIZE(10)) dut10 (
        .clk(clk), .reset(reset), .input_data(in10), .output_data(out10));
    adder_tree_1d_p4 #(.WIDTH(16), .INPUT_SIZE(3)) dut3 (
        .clk(clk), .reset(reset), .input_data(in3), .output_data(out3));
    adder_tree_1d_p4 #(.WIDTH(16), .INPUT_SIZE(1)) dut1 (
        .clk(clk), .reset(reset), .input_data(in1), .output_data(out1));
    adder_tree_1d_p4 #(.WIDTH(16), .INPUT_SIZE(17)) dut17 (
        .clk(clk), .reset(reset), .input_data(in17), .output_data(out17));

    // Reduce one node's integer sum to the 16-bit result the node stores.
    function automatic int fold(input int s);
`ifdef ADDER_TREE_SAT_EN
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
`else
        logic signed [15:0] t;
        t = 16'(s);
        return int'(t);
`endif
    endfunction

    // Reference: group by four level after level using plain integer sums.
    function automatic logic [15:0] model(input int v[$]);
        int cur[$];
        int nxt[$];
        int s;
        cur = v;
        do begin
            nxt = {};
            for (int b = 0; b < cur.size(); b += 4) begin
                s = 0;
                for (int j = b; j < b + 4 && j < cur.size(); j++) s += cur[j];
                nxt.push_back(fold(s));
            end
            cur = nxt;
        end while (cur.size() > 1);
        return 16'(cur[0]);
    endfunction

    function automatic logic [15:0] rv();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all(input logic [15:0] v);
        for (int i = 0; i < 10; i++) in10[i] = v;
        for (int i = 0; i < 3; i++)  in3[i]  = v;
        in1[0] = v;
        for (int i = 0; i < 17; i++) in17[i] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 10; i++) in10[i] = rv();
            tick();
            n_cmp++;
            if (out10 !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d: got %h want 0000", c, out10);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) in10[i] = rv();
        n_cmp++;
        if (out10 !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_deassert0: got %h want 0000", out10);
        end
        tick();
        n_cmp++;
        if (out10 !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_deassert1: got %h want 0000", out10);
        end
    endtask

    task automatic test_latency();
        fill_all(16'h0000);
        tick();
        tick();
        for (int i = 0; i < 10; i++) in10[i] = 16'h0001;
        tick();
        fill_all(16'h0000);
        n_cmp++;
        if (out10 !== 16'h0000) begin
            n_bad++;
            $display("FAIL latency_early: got %h want 0000", out10);
        end
        tick();
        n_cmp++;
        if (out10 !== 16'h000A) begin
            n_bad++;
            $display("FAIL latency_sum: got %h want 000a", out10);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 10; i++) in10[i] = 16'h0001;
        tick();
        for (int i = 0; i < 10; i++) in10[i] = 16'h0010;
        tick();
        n_cmp++;
        if (out10 !== 16'h000A) begin
            n_bad++;
            $display("FAIL stream_a: got %h want 000a", out10);
        end
        for (int i = 0; i < 10; i++) in10[i] = 16'h0000;
        tick();
        n_cmp++;
        if (out10 !== 16'h00A0) begin
            n_bad++;
            $display("FAIL stream_b: got %h want 00a0", out10);
        end
    endtask

`ifndef ADDER_TREE_SAT_EN
    task automatic test_wrap();
        in3[0] = 16'h7FFF; in3[1] = 16'h0001; in3[2] = 16'h0000;
        tick();
        n_cmp++;
        if (out3 !== 16'h8000) begin
            n_bad++;
            $display("FAIL wrap_pos: got %h want 8000", out3);
        end
        in3[0] = -16'sd5; in3[1] = 16'sd3; in3[2] = 16'sd1;
        tick();
        n_cmp++;
        if (out3 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_neg: got %h want ffff", out3);
        end
    endtask
`else
    task automatic test_sat();
        in3[0] = 16'h7FFF; in3[1] = 16'h7FFF; in3[2] = 16'h0001;
        tick();
        n_cmp++;
        if (out3 !== 16'h7FFF) begin
            n_bad++;
            $display("FAIL sat_pos: got %h want 7fff", out3);
        end
        in3[0] = 16'h8000; in3[1] = 16'h8000; in3[2] = 16'h8000;
        tick();
        n_cmp++;
        if (out3 !== 16'h8000) begin
            n_bad++;
            $display("FAIL sat_neg: got %h want 8000", out3);
        end
    endtask
`endif

    task automatic test_edge_sizes();
        in1[0] = 16'h1234;
        for (int i = 0; i < 17; i++) in17[i] = 16'h0000;
        tick();
        n_cmp++;
        if (out1 !== 16'h1234) begin
            n_bad++;
            $display("FAIL n1_pass: got %h want 1234", out1);
        end
        tick();
        tick();
        for (int i = 0; i < 17; i++) in17[i] = 16'h0001;
        tick();
        for (int i = 0; i < 17; i++) in17[i] = 16'h0000;
        tick();
        n_cmp++;
        if (out17 !== 16'h0000) begin
            n_bad++;
            $display("FAIL n17_early: got %h want 0000", out17);
        end
        tick();
        n_cmp++;
        if (out17 !== 16'h0011) begin
            n_bad++;
            $display("FAIL n17_sum: got %h want 0011", out17);
        end
    endtask

    // Random streaming on every instance; rst_cycle >= 0 pulses reset for one cycle.
    task automatic test_random_stream(input int cycles, input int rst_cycle);
        logic [15:0] q10[$], q3[$], q1[$], q17[$];
        logic [15:0] e;
        int v[$];
        for (int c = 0; c < cycles; c++) begin
            reset = (c == rst_cycle);
            v = {};
            for (int i = 0; i < 10; i++) begin in10[i] = rv(); v.push_back(int'(in10[i])); end
            q10.push_back(model(v));
            v = {};
            for (int i = 0; i < 3; i++) begin in3[i] = rv(); v.push_back(int'(in3[i])); end
            q3.push_back(model(v));
            in1[0] = rv();
            v = {};
            v.push_back(int'(in1[0]));
            q1.push_back(model(v));
            v = {};
            for (int i = 0; i < 17; i++) begin in17[i] = rv(); v.push_back(int'(in17[i])); end
            q17.push_back(model(v));
            if (reset) begin
                foreach (q10[i]) q10[i] = 16'h0000;
                foreach (q3[i])  q3[i]  = 16'h0000;
                foreach (q1[i])  q1[i]  = 16'h0000;
                foreach (q17[i]) q17[i] = 16'h0000;
            end
            tick();
            if (q10.size() == 2) begin
                e = q10.pop_front();
                n_cmp++;
                if (out10 !== e) begin
                    n_bad++;
                    $display("FAIL rand_n10 cyc%0d: got %h want %h", c, out10, e);
                end
            end
            if (q3.size() == 1) begin
                e = q3.pop_front();
                n_cmp++;
                if (out3 !== e) begin
                    n_bad++;
                    $display("FAIL rand_n3 cyc%0d: got %h want %h", c, out3, e);
                end
            end
            if (q1.size() == 1) begin
                e = q1.pop_front();
                n_cmp++;
                if (out1 !== e) begin
                    n_bad++;
                    $display("FAIL rand_n1 cyc%0d: got %h want %h", c, out1, e);
                end
            end
            if (q17.size() == 3) begin
                e = q17.pop_front();
                n_cmp++;
                if (out17 !== e) begin
                    n_bad++;
                    $display("FAIL rand_n17 cyc%0d: got %h want %h", c, out17, e);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        fill_all(16'h0000);
        tick();
        test_reset();
        test_latency();
        test_streaming();
`ifndef ADDER_TREE_SAT_EN
        test_wrap();
`else
        test_sat();
`endif
        test_edge_sizes();
        test_random_stream(60, -1);
        test_random_stream(40, 15);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
